// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_NREQ     = 4;
  localparam int unsigned DEF_DSIZE    = 8;
  localparam int unsigned DEF_MAXBURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write-port arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned DSIZE = DEF_DSIZE
);
  logic [NREQ-1:0]       in_req;
  logic [NREQ*DSIZE-1:0] in_data;
  logic                  in_full;
  logic [NREQ-1:0]       out_gnt;
  logic [NREQ-1:0]       out_ack;
  logic                  out_wr_en;
  logic [DSIZE-1:0]      out_wr_data;
  logic                  out_busy;

  // Producers and FIFO flag side
  modport master (
    output in_req, in_data, in_full,
    input  out_gnt, out_ack, out_wr_en, out_wr_data, out_busy
  );

  // Arbiter side
  modport slave (
    input  in_req, in_data, in_full,
    output out_gnt, out_ack, out_wr_en, out_wr_data, out_busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request after index last_i, with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N  = DEF_NREQ,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] pick_o,
  output logic          valid_o
);

  // Scan last+1 .. last+N (mod N), keeping the first hit.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned idx;
      idx = (32'(last_i) + k) % N;
      if (!valid_o && req_i[idx[IW-1:0]]) begin
        pick_o  = idx[IW-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers,
// granting bursts of up to MAXBURST words and stalling on FIFO full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned DSIZE    = DEF_DSIZE,
  parameter int unsigned MAXBURST = DEF_MAXBURST
) (
  input  logic             wrclk,
  input  logic             in_resetn,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned IW = (clog2(NREQ) > 0) ? clog2(NREQ) : 1;
  localparam int unsigned CW = (clog2(MAXBURST) > 0) ? clog2(MAXBURST) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]    pick;
  logic             pick_vld;
  logic             req_g;
  logic             xfer;
  logic [DSIZE-1:0] wr_data;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i   (bus.in_req),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_vld)
  );

  assign req_g = |(gnt_q & bus.in_req);
  assign xfer  = req_g & ~bus.in_full;

  // Forward the granted requester's word; one-hot grant makes OR-mux exact.
  always_comb begin
    wr_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) wr_data = wr_data | bus.in_data[i*DSIZE +: DSIZE];
    end
  end

  assign bus.out_gnt     = gnt_q;
  assign bus.out_ack     = bus.in_full ? '0 : (gnt_q & bus.in_req);
  assign bus.out_wr_en   = xfer;
  assign bus.out_wr_data = wr_data;
  assign bus.out_busy    = (state_q == GRANT);

  // State, grant, last-grant pointer and burst counter registers.
  always_ff @(posedge wrclk or negedge in_resetn) begin
    if (!in_resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration in IDLE; burst accounting and release in GRANT.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_vld) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          last_d      = pick;
          cnt_d       = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!req_g) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (xfer && (cnt_q == CW'(MAXBURST - 1))) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised + directed scoreboard bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned DSIZE    = 8;
  localparam int unsigned MAXBURST = 4;
  localparam int unsigned BOUND    = (NREQ - 1) * (MAXBURST + 1) + 1;

  logic clk;
  logic rstn;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wrclk     (clk),
    .in_resetn (rstn),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  ack;
    logic             wr;
    logic             busy;
    logic [DSIZE-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: who owns the port, how many words it has moved, RR pointer
  int          owner;
  int          used;
  int          last;
  int unsigned seq[NREQ];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  function automatic logic [DSIZE-1:0] word(input int i);
    return DSIZE'((i << 5) | (seq[i] & 31));
  endfunction

  task automatic model_reset();
    owner = -1;
    used  = 0;
    last  = NREQ - 1;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
  endtask

  // One cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input logic [NREQ-1:0] req, input logic full, input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    rstn        = rn;
    bus.in_req  = req;
    bus.in_full = full;
    for (int i = 0; i < NREQ; i++) bus.in_data[i*DSIZE +: DSIZE] = word(i);
    if (!rn) model_reset();
    e.gnt  = '0;
    e.ack  = '0;
    e.wr   = 1'b0;
    e.busy = (owner >= 0);
    e.data = '0;
    if (owner >= 0) begin
      e.gnt[owner] = 1'b1;
      e.data       = word(owner);
      e.wr         = req[owner] && !full;
      if (e.wr) e.ack[owner] = 1'b1;
    end
    exp_q.push_back(e);
    if (!rn) begin
      #1;
      chk("rst_gnt", 32'(bus.out_gnt), 32'd0);
      chk("rst_wr_en", 32'(bus.out_wr_en), 32'd0);
      chk("rst_ack", 32'(bus.out_ack), 32'd0);
    end else begin
      if (owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int idx;
          idx = (last + k) % NREQ;
          if (owner < 0 && req[idx]) begin
            owner = idx;
            last  = idx;
            used  = 0;
          end
        end
      end else if (!req[owner]) begin
        owner = -1;
      end else if (e.wr) begin
        seq[owner]++;
        used++;
        if (used == MAXBURST) owner = -1;
      end
    end
  endtask

  // Monitor: compares every presented cycle and checks global invariants.
  logic [NREQ-1:0] prev_gnt = '0;
  int              wcount   = 0;
  int              waitc[NREQ];
  initial for (int i = 0; i < NREQ; i++) waitc[i] = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("gnt", 32'(bus.out_gnt), 32'(e.gnt));
      chk("ack", 32'(bus.out_ack), 32'(e.ack));
      chk("wr_en", 32'(bus.out_wr_en), 32'(e.wr));
      chk("busy", 32'(bus.out_busy), 32'(e.busy));
      chk("wr_data", 32'(bus.out_wr_data), 32'(e.data));
      chk("full_no_write", 32'(bus.out_wr_en && bus.in_full), 32'd0);
      chk("gnt_onehot0", 32'($countones(bus.out_gnt) <= 1), 32'd1);
      if (bus.out_gnt != prev_gnt) wcount = 0;
      prev_gnt = bus.out_gnt;
      if (bus.out_wr_en) begin
        wcount++;
        chk("burst_len_ok", 32'(wcount <= MAXBURST), 32'd1);
      end
      if (rstn) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!bus.in_req[i] || bus.out_gnt[i]) waitc[i] = 0;
          else if (!bus.in_full) waitc[i]++;
        end
        chk("no_starvation", 32'(waitc[0] <= BOUND && waitc[1] <= BOUND &&
                                 waitc[2] <= BOUND && waitc[3] <= BOUND), 32'd1);
      end
    end
  end

  initial begin
    logic [NREQ-1:0] rq;
    model_reset();
    rstn        = 1'b0;
    bus.in_req  = '0;
    bus.in_full = 1'b0;
    bus.in_data = '0;
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // Single requester: grant, 4 words, idle, re-grant
    repeat (12) step(4'b0001, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    // All requesting: round-robin bursts
    repeat (26) step(4'b1111, 1'b0, 1'b1);
    repeat (2) step(4'b0000, 1'b0, 1'b1);

    // Requester 2 with a 3-cycle full stall after two words
    repeat (3) step(4'b0100, 1'b0, 1'b1);
    repeat (3) step(4'b0100, 1'b1, 1'b1);
    repeat (4) step(4'b0100, 1'b0, 1'b1);
    repeat (2) step(4'b0000, 1'b0, 1'b1);

    // Requester 1 drops after one word while requester 3 waits
    step(4'b0010, 1'b0, 1'b1);
    step(4'b1010, 1'b0, 1'b1);
    repeat (8) step(4'b1000, 1'b0, 1'b1);
    repeat (2) step(4'b0000, 1'b0, 1'b1);

    // Reset in the middle of a requester-0 burst, then restart with all active
    repeat (3) step(4'b0001, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    repeat (12) step(4'b1111, 1'b0, 1'b1);

    // Random traffic with sticky requests and random full
    rq = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
      step(rq, ($urandom_range(0, 4) == 0), 1'b1);
    end

    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO between NREQ producers in the write clock domain. It grants one requester at a time for a bounded burst of up to MAXBURST words. It forwards that requester's data and write strobe to the FIFO write side, and stalls on full. It sits directly in front of the FIFO write-pointer logic: its out_wr_en/out_wr_data feed the FIFO's write enable/data, and its in_full input is the FIFO's full flag.

Parameters:
NREQ, 4, number of requesters (2..8)
DSIZE, 8, data width per word
MAXBURST, 4, max words transferred per grant (1..16)

Ports:
wrclk  input  1  write-domain clock
in_resetn  input  1  asynchronous active-low reset
in_req  input  NREQ  per-requester write request (level, held while data valid)
in_data  input  NREQ*DSIZE  packed data; requester i at bits [i*DSIZE +: DSIZE]
in_full  input  1  FIFO full flag (write domain)
out_gnt  output  NREQ  registered one-hot grant
out_ack  output  NREQ  per-requester word accepted this cycle (combinational)
out_wr_en  output  1  FIFO write enable
out_wr_data  output  DSIZE  FIFO write data
out_busy  output  1  high in GRANT state

Behaviour:
- Reset (async, in_resetn=0):
  - state=IDLE, out_gnt=0, burst count=0.
  - Last-grant pointer=NREQ-1, so requester 0 has top priority first.
  - All outputs 0, including combinational ones, since out_gnt=0.
- Transfer: xfer = |(out_gnt & in_req) & ~in_full.
  - out_wr_en = xfer.
  - out_ack = out_gnt & in_req when ~in_full, else 0.
  - out_wr_data = in_data slice of the granted index (0 when no grant).
- No write is ever issued while in_full=1. Writes drop in the same cycle full rises.
- States:
  - IDLE: out_gnt=0. If in_req!=0, pick the first set bit searching from (last+1) mod NREQ upward with wrap. Next edge: out_gnt=onehot(pick), last=pick, count=0, go to GRANT. Grant latency is 1 cycle from request.
  - GRANT, in priority order:
    - (a) Granted requester deasserts in_req → next edge to IDLE, out_gnt=0.
    - (b) xfer && count==MAXBURST-1 → next edge to IDLE, out_gnt=0.
    - (c) xfer otherwise → count+1, stay in GRANT.
    - (d) in_full stall → hold count and grant.
- One idle cycle always separates consecutive grants (re-arbitration in IDLE).
- Non-granted requests are ignored and never acked, whatever their value.
- count width = clog2(MAXBURST) bits, minimum 1. Increments only on xfer and never wraps; exit happens at MAXBURST-1.
- Fairness: with all requesters active, the grant order is 0,1,2,3,0,… Worst-case wait ≤ (NREQ-1)*(MAXBURST+1)+1 non-stalled cycles.
- Requester protocol: a word is consumed when out_ack[i]=1; the requester advances its data the next cycle.
- MAXBURST=1: every grant lasts exactly until one transfer or a deassert.
- Reset mid-burst: grant is dropped immediately and no further writes occur. The partial burst is not resumed.

Decomposition:
- Package fifo_arb_pkg holds:
  - State enum (IDLE, GRANT).
  - Function clog2.
  - Default constants NREQ/DSIZE/MAXBURST.
- Sub-module rr_pick:
  - Combinational rotating-priority encoder.
  - Inputs: req vector, last index. Outputs: pick index, valid.
  - Reusable for the read-side scheduler.

Test Plan:
- Reset, then in_req=4'b0001, in_full=0, data0=8'hA0..A3 → out_gnt=0001 one cycle later; 4 writes with out_wr_data A0,A1,A2,A3; out_gnt=0 after the 4th write; re-grant to 0 after one IDLE cycle.
- in_req=4'b1111 held → grant sequence 0001,0010,0100,1000,0001; each grant gives 4 writes; 1 idle cycle between grants.
- Requester 2 alone, in_full=1 for 3 cycles mid-burst after 2 words → out_wr_en=0 and count held during the stall; the remaining 2 words are written after full drops; 4 writes total.
- Requester 1 granted, drops in_req after 1 word while in_req[3]=1 → out_gnt=0 next cycle, then out_gnt=1000; only one write attributed to requester 1.
- Assert in_resetn=0 mid-burst with requester 0 granted → out_gnt, out_wr_en, out_ack go to 0 immediately. After release with in_req=1111, the first grant is 0001.
- Random req/full over 10k cycles → checks:
  - no out_wr_en while in_full=1;
  - out_gnt is one-hot or zero;
  - ≤ MAXBURST writes per grant;
  - no starvation beyond the worst-case bound.
